// File: rtl/router_pkg.sv
// Shared definitions for the router control FSM: state encoding, address
// constants and the Moore output decode.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    typedef struct packed {
        logic busy;
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic full_state;
        logic laf_state;
        logic rst_int_reg;
        logic write_enb_reg;
    } ctrl_outs_t;

    // Moore output decode: every strobe is a pure function of the state.
    function automatic ctrl_outs_t decode_outputs(input state_e s);
        ctrl_outs_t o;
        o               = '0;
        o.detect_add    = (s == DECODE_ADDRESS);
        o.lfd_state     = (s == LOAD_FIRST_DATA);
        o.ld_state      = (s == LOAD_DATA);
        o.full_state    = (s == FIFO_FULL_STATE);
        o.laf_state     = (s == LOAD_AFTER_FULL);
        o.rst_int_reg   = (s == CHECK_PARITY_ERROR);
        o.write_enb_reg = (s == LOAD_DATA) || (s == LOAD_PARITY) || (s == LOAD_AFTER_FULL);
        o.busy          = (s != DECODE_ADDRESS) && (s != LOAD_DATA);
        return o;
    endfunction

endpackage

// File: rtl/router_fsm_ctrl.sv
// Control FSM of the 1-in / 3-out packet router. Decodes the destination
// address, sequences header/payload/parity loading into the selected FIFO and
// drives busy, write enable and phase strobes.
// Optional feature: define ROUTER_FSM_SOFT_RESET_EN to let the soft reset of
// the currently addressed FIFO return the FSM to DECODE_ADDRESS.
// Note: resetn is active-high despite its name.
module router_fsm_ctrl
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic              parity_done,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              fifo_full,
    input  logic              low_pkt_valid,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    output logic              busy,
    output logic              detect_add,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              lfd_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg
);

    state_e               state;
    state_e               state_next;
    logic [ADDR_W-1:0]    addr_q;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic                 soft_reset_hit;
    ctrl_outs_t           outs_q;

    assign fifo_empty = {fifo_empty_2, fifo_empty_1, fifo_empty_0};

`ifdef ROUTER_FSM_SOFT_RESET_EN
    logic [NUM_PORTS-1:0] soft_reset;

    assign soft_reset     = {soft_reset_2, soft_reset_1, soft_reset_0};
    // Only the timeout of the FIFO this packet targets may abort it.
    assign soft_reset_hit = (addr_q != ADDR_INVALID) && soft_reset[addr_q];
`else
    logic unused_soft_reset;

    assign unused_soft_reset = ^{soft_reset_2, soft_reset_1, soft_reset_0};
    assign soft_reset_hit    = 1'b0;
`endif

    // Next-state selection from the current state and sampled inputs.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && (data_in != ADDR_INVALID)) begin
                    state_next = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (fifo_empty[addr_q]) state_next = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_next = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_next = FIFO_FULL_STATE;
                else if (!pkt_valid) state_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_next = DECODE_ADDRESS;
                else if (low_pkt_valid) state_next = LOAD_PARITY;
                else                    state_next = LOAD_DATA;
            end
            LOAD_PARITY:        state_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:            state_next = DECODE_ADDRESS;
        endcase
        if (soft_reset_hit) state_next = DECODE_ADDRESS;
    end

    // State, address latch and registered Moore outputs (decoded from the next
    // state so they line up with the state register with no extra latency).
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state  <= DECODE_ADDRESS;
            addr_q <= '0;
            outs_q <= decode_outputs(DECODE_ADDRESS);
        end else begin
            // NOTE: non-blocking so all registers update from pre-edge values.
            state  <= state_next;
            outs_q <= decode_outputs(state_next);
            if ((state == DECODE_ADDRESS) && pkt_valid) addr_q <= data_in;
        end
    end

    assign busy          = outs_q.busy;
    assign detect_add    = outs_q.detect_add;
    assign ld_state      = outs_q.ld_state;
    assign laf_state     = outs_q.laf_state;
    assign full_state    = outs_q.full_state;
    assign lfd_state     = outs_q.lfd_state;
    assign write_enb_reg = outs_q.write_enb_reg;
    assign rst_int_reg   = outs_q.rst_int_reg;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Self-checking bench for router_fsm_ctrl: directed scenarios plus a
// randomized run against a behavioural packet-phase model.
module tb_router_fsm_ctrl;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid, parity_done, fifo_full, low_pkt_valid;
    logic [1:0] data_in;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       busy, detect_add, ld_state, laf_state, full_state, lfd_state;
    logic       write_enb_reg, rst_int_reg;
    logic [7:0] outs;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    router_fsm_ctrl dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid),
        .parity_done(parity_done), .data_in(data_in),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .fifo_full(fifo_full), .low_pkt_valid(low_pkt_valid),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .busy(busy), .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .lfd_state(lfd_state),
        .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg)
    );

    // {busy, detect_add, lfd, ld, full, laf, rst_int, write_enb}
    assign outs = {busy, detect_add, lfd_state, ld_state, full_state, laf_state,
                   rst_int_reg, write_enb_reg};

    // Packet-handling phases of the reference model.
    typedef enum int {P_DEC, P_WAIT, P_LFD, P_LD, P_FULL, P_LAF, P_LP, P_CPE} ph_t;

    ph_t m_ph   = P_DEC;
    int  m_addr = 0;

    function automatic logic [7:0] exp_outs(input ph_t p);
        case (p)
            P_DEC:   return 8'b0100_0000;
            P_WAIT:  return 8'b1000_0000;
            P_LFD:   return 8'b1010_0000;
            P_LD:    return 8'b0001_0001;
            P_FULL:  return 8'b1000_1000;
            P_LAF:   return 8'b1000_0101;
            P_LP:    return 8'b1000_0001;
            default: return 8'b1000_0010;
        endcase
    endfunction

    function automatic logic empty_of(input int a);
        case (a)
            0:       return fifo_empty_0;
            1:       return fifo_empty_1;
            2:       return fifo_empty_2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic soft_of(input int a);
        case (a)
            0:       return soft_reset_0;
            1:       return soft_reset_1;
            2:       return soft_reset_2;
            default: return 1'b0;
        endcase
    endfunction

    // Advance the packet model by one clock using the currently driven inputs.
    task automatic model_step();
        ph_t nx = m_ph;
        int  na = m_addr;
        case (m_ph)
            P_DEC: if (pkt_valid) begin
                na = int'(data_in);
                if (na < 3) nx = empty_of(na) ? P_LFD : P_WAIT;
            end
            P_WAIT:  if (empty_of(m_addr)) nx = P_LFD;
            P_LFD:   nx = P_LD;
            P_LD:    nx = fifo_full ? P_FULL : (!pkt_valid ? P_LP : P_LD);
            P_FULL:  if (!fifo_full) nx = P_LAF;
            P_LAF:   nx = parity_done ? P_DEC : (low_pkt_valid ? P_LP : P_LD);
            P_LP:    nx = P_CPE;
            default: nx = fifo_full ? P_FULL : P_DEC;
        endcase
`ifdef ROUTER_FSM_SOFT_RESET_EN
        if (soft_of(m_addr)) nx = P_DEC;
`endif
        m_ph   = nx;
        m_addr = na;
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        pkt_valid = 0; parity_done = 0; fifo_full = 0; low_pkt_valid = 0; data_in = 2'd0;
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
        fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        idle_inputs();
        resetn = 1;
        m_ph = P_DEC; m_addr = 0;
        @(negedge clock);
        resetn = 0;
    endtask

    task automatic test_reset();
        resetn = 1;
        idle_inputs();
        #12;
        checks++;
        if (outs !== exp_outs(P_DEC)) begin
            errors++; $display("FAIL reset_state: got %b want %b", outs, exp_outs(P_DEC));
        end
        apply_reset();
        // Reach LOAD_DATA, then assert reset between edges.
        pkt_valid = 1; data_in = 2'd0; fifo_empty_0 = 1;
        step(); step();
        checks++;
        if (outs !== exp_outs(P_LD)) begin
            errors++; $display("FAIL reset_pre_ld: got %b want %b", outs, exp_outs(P_LD));
        end
        #2 resetn = 1;
        m_ph = P_DEC; m_addr = 0;
        #1;
        checks++;
        if (outs !== exp_outs(P_DEC)) begin
            errors++; $display("FAIL reset_async_abort: got %b want %b", outs, exp_outs(P_DEC));
        end
        @(negedge clock);
        idle_inputs();
        resetn = 0;
    endtask

    task automatic test_normal_packet();
        apply_reset();
        pkt_valid = 1; data_in = 2'd0; fifo_empty_0 = 1;
        step();
        checks++;
        if (outs !== exp_outs(P_LFD)) begin
            errors++; $display("FAIL normal_lfd: got %b want %b", outs, exp_outs(P_LFD));
        end
        step();
        checks++;
        if (outs !== exp_outs(P_LD)) begin
            errors++; $display("FAIL normal_ld: got %b want %b", outs, exp_outs(P_LD));
        end
        step();
        checks++;
        if (outs !== exp_outs(P_LD)) begin
            errors++; $display("FAIL normal_ld_hold: got %b want %b", outs, exp_outs(P_LD));
        end
        pkt_valid = 0;
        step();
        checks++;
        if (outs !== exp_outs(P_LP)) begin
            errors++; $display("FAIL normal_parity: got %b want %b", outs, exp_outs(P_LP));
        end
        step();
        checks++;
        if (outs !== exp_outs(P_CPE)) begin
            errors++; $display("FAIL normal_check_parity: got %b want %b", outs, exp_outs(P_CPE));
        end
        step();
        checks++;
        if (outs !== exp_outs(P_DEC)) begin
            errors++; $display("FAIL normal_back_to_decode: got %b want %b", outs, exp_outs(P_DEC));
        end
    endtask

    task automatic test_full_path();
        apply_reset();
        pkt_valid = 1; data_in = 2'd2; fifo_empty_2 = 1;
        step(); step();
        fifo_full = 1;
        step();
        checks++;
        if (outs !== exp_outs(P_FULL)) begin
            errors++; $display("FAIL full_enter: got %b want %b", outs, exp_outs(P_FULL));
        end
        fifo_full = 0;
        step();
        checks++;
        if (outs !== exp_outs(P_LAF)) begin
            errors++; $display("FAIL full_laf: got %b want %b", outs, exp_outs(P_LAF));
        end
        parity_done = 0; low_pkt_valid = 0;
        step();
        checks++;
        if (outs !== exp_outs(P_LD)) begin
            errors++; $display("FAIL laf_to_ld: got %b want %b", outs, exp_outs(P_LD));
        end
        fifo_full = 1;
        step();
        fifo_full = 0;
        step();
        parity_done = 1;
        step();
        checks++;
        if (outs !== exp_outs(P_DEC)) begin
            errors++; $display("FAIL laf_parity_done: got %b want %b", outs, exp_outs(P_DEC));
        end
        idle_inputs();
    endtask

    task automatic test_wait_empty();
        apply_reset();
        pkt_valid = 1; data_in = 2'd1; fifo_empty_1 = 0;
        step();
        checks++;
        if (outs !== exp_outs(P_WAIT)) begin
            errors++; $display("FAIL wait_enter: got %b want %b", outs, exp_outs(P_WAIT));
        end
        data_in = 2'd0;
        step();
        checks++;
        if (outs !== exp_outs(P_WAIT)) begin
            errors++; $display("FAIL wait_hold: got %b want %b", outs, exp_outs(P_WAIT));
        end
        fifo_empty_1 = 1;
        step();
        checks++;
        if (outs !== exp_outs(P_LFD)) begin
            errors++; $display("FAIL wait_release: got %b want %b", outs, exp_outs(P_LFD));
        end
        step();
        fifo_full = 1;
        step();
        fifo_full = 0;
        step();
        low_pkt_valid = 1;
        step();
        checks++;
        if (outs !== exp_outs(P_LP)) begin
            errors++; $display("FAIL laf_low_pkt_valid: got %b want %b", outs, exp_outs(P_LP));
        end
        idle_inputs();
        step(); step();
        checks++;
        if (outs !== exp_outs(P_DEC)) begin
            errors++; $display("FAIL wait_done: got %b want %b", outs, exp_outs(P_DEC));
        end
    endtask

    task automatic test_invalid_addr();
        apply_reset();
        pkt_valid = 1; data_in = 2'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (outs !== exp_outs(P_DEC)) begin
                errors++; $display("FAIL invalid_addr_cycle%0d: got %b want %b", i, outs, exp_outs(P_DEC));
            end
        end
        idle_inputs();
    endtask

    task automatic test_soft_reset();
        ph_t want;
        apply_reset();
        pkt_valid = 1; data_in = 2'd2; fifo_empty_2 = 1;
        step(); step();
        fifo_full = 1;
        step();
        soft_reset_0 = 1;
        step();
        checks++;
        if (outs !== exp_outs(P_FULL)) begin
            errors++; $display("FAIL soft_reset_other_port: got %b want %b", outs, exp_outs(P_FULL));
        end
        soft_reset_0 = 0; soft_reset_2 = 1;
        step();
`ifdef ROUTER_FSM_SOFT_RESET_EN
        want = P_DEC;
`else
        want = P_FULL;
`endif
        checks++;
        if (outs !== exp_outs(want)) begin
            errors++; $display("FAIL soft_reset_own_port: got %b want %b", outs, exp_outs(want));
        end
        idle_inputs();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            pkt_valid     = ($urandom_range(0, 3) != 0);
            data_in       = 2'($urandom);
            fifo_full     = ($urandom_range(0, 3) == 0);
            parity_done   = ($urandom_range(0, 3) == 0);
            low_pkt_valid = ($urandom_range(0, 1) == 0);
            fifo_empty_0  = ($urandom_range(0, 2) != 0);
            fifo_empty_1  = ($urandom_range(0, 2) != 0);
            fifo_empty_2  = ($urandom_range(0, 2) != 0);
            soft_reset_0  = ($urandom_range(0, 15) == 0);
            soft_reset_1  = ($urandom_range(0, 15) == 0);
            soft_reset_2  = ($urandom_range(0, 15) == 0);
            step();
            checks++;
            if (outs !== exp_outs(m_ph)) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b want %b", i, outs, exp_outs(m_ph));
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_normal_packet();
        test_full_path();
        test_wait_empty();
        test_invalid_addr();
        test_soft_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
